// File: rtl/alu_verilog.sv
`default_nettype none
// ============================================================================
// Module      : alu_verilog
// Description : Registered 16-bit ALU with sixteen operations. Operands and
//               opcode are sampled every rising edge. The result and the
//               Z/N/C/V status flags are valid one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_verilog (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] op,
    output logic [15:0] c,
    output logic [3:0]  flags
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_NOT  = 4'd5;
    localparam logic [3:0] c_OP_SHL  = 4'd6;
    localparam logic [3:0] c_OP_SHR  = 4'd7;
    localparam logic [3:0] c_OP_ASR  = 4'd8;
    localparam logic [3:0] c_OP_ROL  = 4'd9;
    localparam logic [3:0] c_OP_ROR  = 4'd10;
    localparam logic [3:0] c_OP_MUL  = 4'd11;
    localparam logic [3:0] c_OP_CMP  = 4'd12;
    localparam logic [3:0] c_OP_INC  = 4'd13;
    localparam logic [3:0] c_OP_DEC  = 4'd14;
    localparam logic [3:0] c_OP_PASS = 4'd15;

    logic [15:0] r_c;
    logic [3:0]  r_flags;

    logic        w_legal;
    logic [3:0]  w_sh;
    logic [3:0]  w_shl_idx;
    logic [3:0]  w_shr_idx;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [16:0] w_inc;
    logic [16:0] w_dec;
    logic [31:0] w_prod;
    logic [15:0] w_rol;
    logic [15:0] w_ror;
    logic [15:0] w_res;
    logic        w_cy;
    logic        w_v;
    logic        w_keep;

    assign w_legal   = (op[15:4] == 12'd0);
    assign w_sh      = b[3:0];
    // Index of the last bit shifted out: 16-n for left shifts, n-1 for right.
    assign w_shl_idx = 4'd0 - w_sh;
    assign w_shr_idx = w_sh - 4'd1;
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_inc     = {1'b0, a} + 17'd1;
    assign w_dec     = {1'b0, a} - 17'd1;
    assign w_prod    = {16'd0, a} * {16'd0, b};
    // A zero amount shifts the complementary part by 16, which yields zero.
    assign w_rol     = (a << w_sh) | (a >> (5'd16 - {1'b0, w_sh}));
    assign w_ror     = (a >> w_sh) | (a << (5'd16 - {1'b0, w_sh}));

    // Result and carry/overflow selection; illegal opcodes fall through to a
    // zero result, which yields Z=1 with every other flag clear.
    always_comb begin
        w_res  = 16'h0000;
        w_cy   = 1'b0;
        w_v    = 1'b0;
        w_keep = 1'b0;
        if (w_legal) begin
            case (op[3:0])
                c_OP_ADD: begin
                    w_res = w_sum[15:0];
                    w_cy  = w_sum[16];
                    w_v   = (a[15] == b[15]) && (w_sum[15] != a[15]);
                end
                c_OP_SUB, c_OP_CMP: begin
                    w_res  = w_diff[15:0];
                    w_cy   = w_diff[16];
                    w_v    = (a[15] != b[15]) && (w_diff[15] != a[15]);
                    w_keep = (op[3:0] == c_OP_CMP);
                end
                c_OP_AND: w_res = a & b;
                c_OP_OR:  w_res = a | b;
                c_OP_XOR: w_res = a ^ b;
                c_OP_NOT: w_res = ~a;
                c_OP_SHL: begin
                    w_res = a << w_sh;
                    w_cy  = (w_sh != 4'd0) && a[w_shl_idx];
                end
                c_OP_SHR: begin
                    w_res = a >> w_sh;
                    w_cy  = (w_sh != 4'd0) && a[w_shr_idx];
                end
                c_OP_ASR: begin
                    w_res = $signed(a) >>> w_sh;
                    w_cy  = (w_sh != 4'd0) && a[w_shr_idx];
                end
                c_OP_ROL: begin
                    w_res = w_rol;
                    w_cy  = (w_sh != 4'd0) && w_rol[0];
                end
                c_OP_ROR: begin
                    w_res = w_ror;
                    w_cy  = (w_sh != 4'd0) && w_ror[15];
                end
                c_OP_MUL: begin
                    w_res = w_prod[15:0];
                    w_cy  = (w_prod[31:16] != 16'd0);
                end
                c_OP_INC: begin
                    w_res = w_inc[15:0];
                    w_cy  = w_inc[16];
                    w_v   = !a[15] && w_inc[15];
                end
                c_OP_DEC: begin
                    w_res = w_dec[15:0];
                    w_cy  = w_dec[16];
                    w_v   = a[15] && !w_dec[15];
                end
                c_OP_PASS: w_res = b;
                default:   w_res = 16'h0000;
            endcase
        end
    end

    // Output registers; CMP updates only the flags and leaves c untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c     <= 16'h0000;
            r_flags <= 4'h0;
        end else begin
            if (!w_keep) begin
                r_c <= w_res;
            end
            r_flags <= {w_v, w_cy, w_res[15], (w_res == 16'h0000)};
        end
    end

    assign c     = r_c;
    assign flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_verilog.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_verilog
// Description : Scoreboard bench for alu_verilog. Directed vectors plus a
//               random stream are checked against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_verilog;

    logic        clk;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] op;
    logic [15:0] c;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] r_expq [$];
    logic [15:0] r_prev_c;

    alu_verilog dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .c     (c),
        .flags (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {flags[3:0], c[15:0]} from plain integer math.
    function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic [15:0] mop, input logic [15:0] prevc);
        int   ua, ub, sa, sb, r, sv, n;
        logic cf, vf;
        logic [15:0] res;
        logic [15:0] cout;
        logic [15:0] rot;
        logic        bit0;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        n  = int'(mb[3:0]);
        r  = 0; cf = 1'b0; vf = 1'b0;
        if (mop > 16'd15) begin
            return {4'b0001, 16'h0000};
        end
        case (int'(mop))
            0:  begin r = ua + ub; cf = (r > 65535); sv = sa + sb; vf = (sv > 32767) || (sv < -32768); end
            1, 12: begin r = ua - ub; cf = (ua < ub); sv = sa - sb; vf = (sv > 32767) || (sv < -32768); end
            2:  r = ua & ub;
            3:  r = ua | ub;
            4:  r = ua ^ ub;
            5:  r = ~ua;
            6:  begin r = ua << n; cf = (n != 0) && (((ua >> (16 - n)) & 1) == 1); end
            7:  begin r = ua >> n; cf = (n != 0) && (((ua >> (n - 1)) & 1) == 1); end
            8:  begin r = sa >>> n; cf = (n != 0) && (((ua >> (n - 1)) & 1) == 1); end
            9:  begin
                    rot = ma;
                    for (int i = 0; i < n; i++) begin bit0 = rot[15]; rot = {rot[14:0], bit0}; end
                    r = int'(rot); cf = (n != 0) && rot[0];
                end
            10: begin
                    rot = ma;
                    for (int i = 0; i < n; i++) begin bit0 = rot[0]; rot = {bit0, rot[15:1]}; end
                    r = int'(rot); cf = (n != 0) && rot[15];
                end
            11: begin
                    longint p;
                    p = longint'(ua) * longint'(ub);
                    r = int'(p & 64'hFFFF); cf = (p > 65535);
                end
            13: begin r = ua + 1; cf = (r > 65535); vf = (sa + 1 > 32767); end
            14: begin r = ua - 1; cf = (ua < 1); vf = (sa - 1 < -32768); end
            default: r = ub;
        endcase
        res  = r[15:0];
        cout = (mop == 16'd12) ? prevc : res;
        return {vf, cf, res[15], (res == 16'h0000), cout};
    endfunction

    // Issue one operation: drive between edges and record the expected result.
    task automatic drive(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] top);
        logic [19:0] e;
        @(negedge clk);
        a  = ta;
        b  = tb;
        op = top;
        e  = model(ta, tb, top, r_prev_c);
        r_expq.push_back(e);
        r_prev_c = e[15:0];
    endtask

    task automatic check_now(input string name, input logic [15:0] ec, input logic [3:0] ef);
        n_checks++;
        if (c === ec && flags === ef) n_pass++;
        else $display("FAIL %s: got c=%h flags=%b, expected c=%h flags=%b", name, c, flags, ec, ef);
    endtask

    // Monitor: every edge out of reset presents a new result; compare it.
    always @(posedge clk) begin
        logic [19:0] e;
        #1;
        if (reset && r_expq.size() > 0) begin
            e = r_expq.pop_front();
            n_checks++;
            if (c === e[15:0] && flags === e[19:16]) n_pass++;
            else $display("FAIL scoreboard: got c=%h flags=%b, expected c=%h flags=%b (t=%0t)",
                          c, flags, e[15:0], e[19:16], $time);
        end
    end

    initial begin
        reset    = 1'b0;
        a        = 16'h00FF;
        b        = 16'h0001;
        op       = 16'h0000;
        r_prev_c = 16'h0000;

        repeat (2) @(posedge clk);
        #1 check_now("reset_hold", 16'h0000, 4'b0000);

        @(negedge clk);
        reset = 1'b1;
        drive(16'h00FF, 16'h0001, 16'd0);
        drive(16'hFFFF, 16'h0001, 16'd0);
        drive(16'h7FFF, 16'h0001, 16'd0);
        drive(16'h0001, 16'h0002, 16'd1);
        drive(16'd5,    16'd5,    16'd12);
        drive(16'h8001, 16'd1,    16'd6);
        drive(16'h8000, 16'd15,   16'd8);
        drive(16'h0001, 16'd1,    16'd10);
        drive(16'h0100, 16'h0100, 16'd11);
        drive(16'h1234, 16'h5678, 16'h0010);
        drive(16'h7FFF, 16'h0000, 16'd13);
        drive(16'h8000, 16'h0000, 16'd14);
        drive(16'h0000, 16'h0000, 16'd14);
        drive(16'h1234, 16'h0010, 16'd9);
        drive(16'hA5A5, 16'h0000, 16'd6);

        // Mid-stream asynchronous reset discards the pending operation.
        drive(16'h1111, 16'h2222, 16'd0);
        #2 reset = 1'b0;
        #1 check_now("async_reset", 16'h0000, 4'b0000);
        r_expq.delete();
        r_prev_c = 16'h0000;
        @(posedge clk);
        #1 check_now("reset_edge", 16'h0000, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        drive(16'h0003, 16'h0004, 16'd0);
        drive(16'h0009, 16'h0009, 16'd12);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] ro;
            if ($urandom_range(0, 9) == 0) ro = {12'($urandom_range(1, 4095)), 4'($urandom)};
            else ro = 16'($urandom_range(0, 15));
            drive(16'($urandom), 16'($urandom), ro);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (r_expq.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending results, expected 0", r_expq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_verilog.md
# alu_verilog

Registered 16-bit arithmetic/logic unit: each rising clock edge it samples operands `a`, `b` and opcode `op`, computes one of sixteen operations and updates result `c` and status `flags`. It is the standalone execution block of the example datapath, fed directly by upstream registers and read by downstream logic one cycle later.

## Interface
- Parameters: none. Data width is fixed at 16 bits.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `a`  input  16  operand A.
- `b`  input  16  operand B; for shifts and rotates, `b[3:0]` is the amount.
- `op`  input  16  opcode; only `op[3:0]` is decoded when `op[15:4]` is zero.
- `c`  output  16  registered result.
- `flags`  output  4  registered status: bit 0 Z (zero), bit 1 N (negative, `c[15]`), bit 2 C (carry/borrow/shift-out), bit 3 V (signed overflow).

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT a.
  - 6 SHL: a << b[3:0].
  - 7 SHR: logical right shift.
  - 8 ASR: arithmetic right shift.
  - 9 ROL.
  - 10 ROR.
  - 11 MUL: low 16 bits of a×b, unsigned.
  - 12 CMP: a−b; flags as SUB, `c` unchanged.
  - 13 INC: a+1.
  - 14 DEC: a−1.
  - 15 PASS: c = b.
- Any `op` with `op[15:4]` ≠ 0 is illegal: c = 0x0000, flags = 0001 (Z=1, N=C=V=0).
- Z = 1 when the 16-bit result is 0. N = bit 15 of the result. For CMP, Z and N come from the discarded difference.
- C:
  - ADD/INC: carry out of bit 15.
  - SUB/CMP/DEC: borrow, i.e. 1 when the unsigned minuend < subtrahend.
  - SHL: last bit shifted out of bit 15.
  - SHR/ASR: last bit shifted out of bit 0.
  - ROL: new `c[0]`. ROR: new `c[15]`.
  - Shift/rotate amount 0: C = 0.
  - MUL: 1 when the upper 16 product bits are non-zero.
  - Logic ops, NOT, PASS: 0.
- V:
  - ADD/INC: operands same sign, result sign differs.
  - SUB/CMP/DEC: operands differ in sign, result sign differs from a.
  - All other ops: 0.
- All arithmetic is modulo 2^16. No saturation.

## Timing
- Latency is 1 cycle. Inputs are sampled on rising edge k; `c` and `flags` are valid after edge k and held until the next edge.
- Every cycle updates the outputs. There is no enable and no handshake.
- While `reset` is low (asynchronous, independent of `clk`): c = 0x0000, flags = 0000 immediately.
- Deasserting `reset`: the first rising edge with `reset` high loads a result.
- Reset asserted mid-stream: outputs clear at once, and the pending computation is discarded.
- Inputs changing between edges have no effect on the outputs.

## Test plan
- Reset low with a=0x00FF, b=0x0001, op=0 → c=0x0000, flags=0000. After release, next edge → c=0x0100, flags=0000.
- ADD a=0xFFFF, b=0x0001 → c=0x0000, flags Z=1, C=1 (0101). ADD a=0x7FFF, b=0x0001 → c=0x8000, N=1, V=1 (1010).
- SUB a=0x0001, b=0x0002 → c=0xFFFF, N=1, C=1 (0110). CMP a=5, b=5 → c keeps its prior value, Z=1.
- SHL a=0x8001, b=1 → c=0x0002, C=1. ASR a=0x8000, b=15 → c=0xFFFF, N=1. ROR a=0x0001, b=1 → c=0x8000, C=1.
- MUL a=0x0100, b=0x0100 → c=0x0000, Z=1, C=1. Illegal op=0x0010 → c=0x0000, flags=0001.
- Assert `reset` low between clock edges during an op stream → outputs zero without waiting for an edge. After release, the stream resumes with 1-cycle latency.
